// File: rtl/camera_clock_reconfig_controller_if.sv
// Request/status bus plus DCM_CLKGEN program and lock port for the camera
// clock reconfiguration controller. The slave side is the controller; the
// master side is its environment (requester and the DCM primitive).
interface camera_clock_reconfig_controller_if;
  logic [7:0] cfg_m_minus1;
  logic [7:0] cfg_d_minus1;
  logic       cfg_start;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_error;
  logic       dcm_progen;
  logic       dcm_progdata;
  logic       dcm_progdone;
  logic       dcm_locked;
  logic       dcm_reset;
  logic       clk_ready;

  modport master (
    output cfg_m_minus1, cfg_d_minus1, cfg_start, dcm_progdone, dcm_locked,
    input  cfg_busy, cfg_done, cfg_error, dcm_progen, dcm_progdata, dcm_reset, clk_ready
  );

  modport slave (
    input  cfg_m_minus1, cfg_d_minus1, cfg_start, dcm_progdone, dcm_locked,
    output cfg_busy, cfg_done, cfg_error, dcm_progen, dcm_progdata, dcm_reset, clk_ready
  );
endinterface

// File: rtl/camera_clock_reconfig_controller.sv
// Camera clock reconfiguration controller: serially programs M/D into a
// DCM_CLKGEN, waits for PROGDONE and LOCKED, and recovers from lock loss or
// timeouts by pulsing the DCM reset and reprogramming the latched setting.
module camera_clock_reconfig_controller #(
  parameter int LOCK_TIMEOUT = 100000,
  parameter int RESET_CYCLES = 10,
  parameter int MAX_RETRIES  = 3,
  parameter int DONE_TIMEOUT = 1000
) (
  input logic                                   input_clk,
  input logic                                   reset,
  camera_clock_reconfig_controller_if.slave     bus
);

  // Each serial word (two header bits plus eight data bits) takes ten cycles.
  localparam int LOAD_CYCLES = 10;
  localparam int MAX_A   = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
  localparam int MAX_B   = (RESET_CYCLES > LOAD_CYCLES) ? RESET_CYCLES : LOAD_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 2);

  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, WAIT_LOCK, DCM_RST, FAIL
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [7:0]    m_reg, m_next;
  logic [7:0]    d_reg, d_next;
  // A user request is in flight; only those end with a cfg_done pulse.
  logic          req_reg, req_next;
  logic          error_reg, error_next;
  logic          ready_reg, ready_next;
  logic          done_reg, done_next;
  logic          progen_reg, progen_next;
  logic          progdata_reg, progdata_next;
  logic          dcm_reset_reg, dcm_reset_next;
  logic          busy_reg, busy_next;
  logic          take_recovery;
  logic [2:0]    bit_sel;

  // Next-state logic; outputs are decoded from the next state so they leave
  // the register aligned with the state they belong to.
  always_comb begin
    state_next    = state_reg;
    retry_next    = retry_reg;
    m_next        = m_reg;
    d_next        = d_reg;
    req_next      = req_reg;
    error_next    = error_reg;
    ready_next    = ready_reg;
    done_next     = 1'b0;
    take_recovery = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ready_reg && !bus.dcm_locked) begin
          // Autonomous relock: the DCM lost lock at the current setting.
          ready_next = 1'b0;
          retry_next = '0;
          req_next   = 1'b0;
          state_next = DCM_RST;
        end else if (bus.cfg_start) begin
          if (bus.cfg_m_minus1 == 8'd0) begin
            error_next = 1'b1;
          end else begin
            m_next     = bus.cfg_m_minus1;
            d_next     = bus.cfg_d_minus1;
            error_next = 1'b0;
            retry_next = '0;
            ready_next = 1'b0;
            req_next   = 1'b1;
            state_next = LOAD_D;
          end
        end
      end
      LOAD_D:    if (cnt_reg == LOAD_LAST) state_next = GAP_D;
      GAP_D:     state_next = LOAD_M;
      LOAD_M:    if (cnt_reg == LOAD_LAST) state_next = GAP_M;
      GAP_M:     state_next = GO;
      GO:        state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.dcm_progdone)          state_next = WAIT_LOCK;
        else if (cnt_reg == DONE_LAST) take_recovery = 1'b1;
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (bus.dcm_locked) begin
          state_next = IDLE;
          ready_next = 1'b1;
          done_next  = req_reg;
          req_next   = 1'b0;
        end else if (cnt_reg == LOCK_LAST) begin
          take_recovery = 1'b1;
        end
      end
      DCM_RST: begin
        // M latch of zero means nothing was ever programmed: wait for the
        // DCM's default lock instead of reprogramming.
        if (cnt_reg == RST_LAST) state_next = (m_reg == 8'd0) ? WAIT_LOCK : LOAD_D;
      end
      FAIL:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase

    if (take_recovery) begin
      if (retry_reg < RETRY_MAX) begin
        retry_next = retry_reg + 1'b1;
        state_next = DCM_RST;
      end else begin
        state_next = FAIL;
      end
    end

    if (state_next == FAIL) begin
      error_next = 1'b1;
      ready_next = 1'b0;
      req_next   = 1'b0;
    end
  end

  // Per-state cycle counter: cleared on every state change, saturates.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) cnt_next = '0;
    else if (cnt_reg != CNT_SAT) cnt_next = cnt_reg + 1'b1;
  end

  // Output decode for the upcoming state, including the serial bit select.
  always_comb begin
    bit_sel        = 3'(cnt_next - CW'(2));
    progen_next    = (state_next == LOAD_D) || (state_next == LOAD_M) || (state_next == GO);
    dcm_reset_next = (state_next == DCM_RST);
    busy_next      = (state_next != IDLE) && (state_next != FAIL);
    progdata_next  = 1'b0;
    case (state_next)
      LOAD_D: begin
        if (cnt_next == '0)              progdata_next = 1'b1;
        else if (cnt_next == CW'(1))     progdata_next = 1'b0;
        else                             progdata_next = d_next[bit_sel];
      end
      LOAD_M: begin
        if (cnt_next < CW'(2))           progdata_next = 1'b1;
        else                             progdata_next = m_next[bit_sel];
      end
      default:                           progdata_next = 1'b0;
    endcase
  end

  // State and output registers; reset parks in DCM_RST with the DCM held in reset.
  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_reg     <= DCM_RST;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      m_reg         <= '0;
      d_reg         <= '0;
      req_reg       <= 1'b0;
      error_reg     <= 1'b0;
      ready_reg     <= 1'b0;
      done_reg      <= 1'b0;
      progen_reg    <= 1'b0;
      progdata_reg  <= 1'b0;
      dcm_reset_reg <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      m_reg         <= m_next;
      d_reg         <= d_next;
      req_reg       <= req_next;
      error_reg     <= error_next;
      ready_reg     <= ready_next;
      done_reg      <= done_next;
      progen_reg    <= progen_next;
      progdata_reg  <= progdata_next;
      dcm_reset_reg <= dcm_reset_next;
      busy_reg      <= busy_next;
    end
  end

  assign bus.cfg_busy     = busy_reg;
  assign bus.cfg_done     = done_reg;
  assign bus.cfg_error    = error_reg;
  assign bus.dcm_progen   = progen_reg;
  assign bus.dcm_progdata = progdata_reg;
  assign bus.dcm_reset    = dcm_reset_reg;
  assign bus.clk_ready    = ready_reg;

endmodule

// File: tb/tb_camera_clock_reconfig_controller.sv
// Bench for camera_clock_reconfig_controller: a behavioural DCM_CLKGEN model
// answers the program port, a vector table drives programming requests and
// hand-written sequences cover power-up, relock, retry exhaustion and reset.
module tb_camera_clock_reconfig_controller;
  localparam int LOCK_TO  = 50;
  localparam int RST_CYC  = 10;
  localparam int RETRIES  = 3;
  localparam int DONE_TO  = 40;

  logic input_clk = 1'b0;
  logic reset     = 1'b1;

  camera_clock_reconfig_controller_if bus();

  camera_clock_reconfig_controller #(
    .LOCK_TIMEOUT(LOCK_TO),
    .RESET_CYCLES(RST_CYC),
    .MAX_RETRIES (RETRIES),
    .DONE_TIMEOUT(DONE_TO)
  ) dut (
    .input_clk(input_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 input_clk = ~input_clk;

  int checks = 0;
  int errors = 0;

  // DCM model knobs (written only by the stimulus process)
  int done_delay   = 5;
  int lock_delay   = 20;
  bit lock_en      = 1'b1;
  int drop_req_cnt = 0;

  // DCM model state and logs (written only by the model process)
  int   drop_seen_cnt = 0;
  bit   drop_restore  = 1'b0;
  int   blen = 0, done_cnt = -1, lock_cnt = -1, rst_run = 0, done_pulses = 0;
  logic bits[$];
  int   rst_widths[$];

  // Behavioural DCM_CLKGEN: logs the serial stream, answers GO with PROGDONE,
  // then LOCKED; LOCKED drops on RST and on GO.
  always @(negedge input_clk) begin
    if (bus.dcm_progen === 1'b1) begin
      bits.push_back(bus.dcm_progdata);
      blen++;
    end else begin
      if (blen == 1) begin
        done_cnt       = done_delay;
        bus.dcm_locked = 1'b0;
      end
      blen = 0;
    end
    if (bus.cfg_done === 1'b1) done_pulses++;
    if (bus.dcm_reset === 1'b1) begin
      rst_run++;
      bus.dcm_locked   = 1'b0;
      bus.dcm_progdone = 1'b0;
      done_cnt         = -1;
      lock_cnt         = -1;
      drop_restore     = 1'b0;
      drop_seen_cnt    = drop_req_cnt;
    end else begin
      if (rst_run > 0) begin
        rst_widths.push_back(rst_run);
        rst_run  = 0;
        lock_cnt = lock_en ? lock_delay : -1;
      end
      bus.dcm_progdone = 1'b0;
      if (done_cnt == 0) begin
        bus.dcm_progdone = 1'b1;
        done_cnt         = -1;
        lock_cnt         = lock_en ? lock_delay : -1;
      end else if (done_cnt > 0) begin
        done_cnt--;
      end
      if (lock_cnt == 0) begin
        bus.dcm_locked = 1'b1;
        lock_cnt       = -1;
      end else if (lock_cnt > 0) begin
        lock_cnt--;
      end
      if (drop_seen_cnt != drop_req_cnt) begin
        drop_seen_cnt  = drop_req_cnt;
        bus.dcm_locked = 1'b0;
        drop_restore   = 1'b1;
      end else if (drop_restore) begin
        bus.dcm_locked = 1'b1;
        drop_restore   = 1'b0;
      end
    end
  end

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  d;
    int          exp_nbits;
    logic [20:0] exp_stream;
    logic        exp_error;
    int          exp_done;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(negedge input_clk);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(string name, int bound);
    int n = 0;
    while (bus.cfg_busy !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    if (bus.cfg_busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: cfg_busy=%b after %0d cycles, expected 0", name, bus.cfg_busy, bound);
    end
  endtask

  task automatic issue(logic [7:0] m, logic [7:0] d);
    bus.cfg_m_minus1 = m;
    bus.cfg_d_minus1 = d;
    bus.cfg_start    = 1'b1;
    step();
    bus.cfg_start    = 1'b0;
  endtask

  function automatic logic [20:0] stream21(int base);
    logic [20:0] s = '0;
    for (int i = 0; i < 21; i++) begin
      if (base + i < bits.size()) s = {s[19:0], bits[base + i]};
      else                        s = {s[19:0], 1'b0};
    end
    return s;
  endfunction

  // Releases reset (caller holds it) and checks the power-up sequence.
  task automatic powerup_check(string tag);
    int w, n, b, dp;
    b  = bits.size();
    dp = done_pulses;
    reset = 1'b0;
    w = (bus.dcm_reset === 1'b1) ? 1 : 0;
    n = 0;
    step();
    while (bus.dcm_reset === 1'b1 && n < 100) begin
      w++;
      n++;
      step();
    end
    check({tag, "_rst_width"}, w, RST_CYC);
    wait_idle(tag, 300);
    step();
    check({tag, "_ready"}, bus.clk_ready, 1);
    check({tag, "_no_done"}, done_pulses - dp, 0);
    check({tag, "_no_prog"}, bits.size() - b, 0);
    check({tag, "_error"}, bus.cfg_error, 0);
    $display("txn %s: dcm_reset width %0d, clk_ready=%b", tag, w, bus.clk_ready);
  endtask

  initial begin
    int b, dp, rw, n;
    vecs[0] = '{8'd30,  8'd31,  21, 21'b1011111000_1101111000_0, 1'b0, 1, 1'b1};
    vecs[1] = '{8'd0,   8'd5,   0,  21'b0,                        1'b1, 0, 1'b1};
    vecs[2] = '{8'd1,   8'd0,   21, 21'b1000000000_1110000000_0, 1'b0, 1, 1'b1};
    vecs[3] = '{8'd255, 8'd255, 21, 21'b1011111111_1111111111_0, 1'b0, 1, 1'b1};
    vecs[4] = '{8'h5A,  8'hA5,  21, 21'b1010100101_1101011010_0, 1'b0, 1, 1'b1};

    bus.cfg_m_minus1 = '0;
    bus.cfg_d_minus1 = '0;
    bus.cfg_start    = 1'b0;
    reset            = 1'b1;
    repeat (3) step();

    // Held reset
    check("rst_dcm_reset", bus.dcm_reset, 1);
    check("rst_progen", bus.dcm_progen, 0);
    check("rst_progdata", bus.dcm_progdata, 0);
    check("rst_busy", bus.cfg_busy, 0);
    check("rst_done", bus.cfg_done, 0);
    check("rst_error", bus.cfg_error, 0);
    check("rst_ready", bus.clk_ready, 0);
    $display("txn reset_hold: dcm_reset=%b progen=%b", bus.dcm_reset, bus.dcm_progen);

    powerup_check("powerup");

    // Table of programming requests
    for (int i = 0; i < 5; i++) begin
      b  = bits.size();
      dp = done_pulses;
      issue(vecs[i].m, vecs[i].d);
      check($sformatf("row%0d_busy_at_start", i), bus.cfg_busy, (vecs[i].exp_nbits != 0) ? 1 : 0);
      check($sformatf("row%0d_error_at_start", i), bus.cfg_error, vecs[i].exp_error);
      if (vecs[i].exp_nbits == 0) check($sformatf("row%0d_progen", i), bus.dcm_progen, 0);
      wait_idle($sformatf("row%0d", i), 500);
      step();
      step();
      check($sformatf("row%0d_nbits", i), bits.size() - b, vecs[i].exp_nbits);
      check($sformatf("row%0d_stream", i), int'(stream21(b)), int'(vecs[i].exp_stream));
      check($sformatf("row%0d_done", i), done_pulses - dp, vecs[i].exp_done);
      check($sformatf("row%0d_error", i), bus.cfg_error, vecs[i].exp_error);
      check($sformatf("row%0d_ready", i), bus.clk_ready, vecs[i].exp_ready);
      $display("txn row%0d: m=%0d d=%0d bits=%0d stream=%06h done=%0d error=%b ready=%b",
               i, vecs[i].m, vecs[i].d, bits.size() - b, stream21(b), done_pulses - dp,
               bus.cfg_error, bus.clk_ready);
    end

    // Starts while busy are ignored
    b  = bits.size();
    dp = done_pulses;
    issue(8'd30, 8'd31);
    repeat (3) step();
    issue(8'h11, 8'h22);
    step();
    issue(8'd0, 8'd0);
    check("busy_ign_error", bus.cfg_error, 0);
    wait_idle("busy_ign", 500);
    step();
    step();
    check("busy_ign_nbits", bits.size() - b, 21);
    check("busy_ign_stream", int'(stream21(b)), int'(21'b1011111000_1101111000_0));
    check("busy_ign_done", done_pulses - dp, 1);
    $display("txn busy_ignore: stream=%06h done=%0d", stream21(b), done_pulses - dp);

    // Autonomous relock after a one-cycle lock drop
    b  = bits.size();
    dp = done_pulses;
    rw = rst_widths.size();
    drop_req_cnt++;
    step();
    step();
    check("relock_ready_low", bus.clk_ready, 0);
    check("relock_dcm_reset", bus.dcm_reset, 1);
    wait_idle("relock", 500);
    step();
    step();
    check("relock_npulses", rst_widths.size() - rw, 1);
    check("relock_width", (rst_widths.size() > rw) ? rst_widths[rw] : -1, RST_CYC);
    check("relock_stream", int'(stream21(b)), int'(21'b1011111000_1101111000_0));
    check("relock_ready", bus.clk_ready, 1);
    check("relock_no_done", done_pulses - dp, 0);
    $display("txn relock: pulses=%0d ready=%b done=%0d", rst_widths.size() - rw, bus.clk_ready, done_pulses - dp);

    // Lock never returns: retries exhausted
    lock_en = 1'b0;
    b  = bits.size();
    dp = done_pulses;
    rw = rst_widths.size();
    issue(8'd1, 8'd0);
    wait_idle("retry", 2000);
    step();
    step();
    check("retry_npulses", rst_widths.size() - rw, RETRIES);
    for (int k = rw; k < rst_widths.size(); k++)
      check($sformatf("retry_width%0d", k - rw), rst_widths[k], RST_CYC);
    check("retry_nbits", bits.size() - b, 21 * (RETRIES + 1));
    check("retry_error", bus.cfg_error, 1);
    check("retry_ready", bus.clk_ready, 0);
    check("retry_no_done", done_pulses - dp, 0);
    $display("txn retry: pulses=%0d bits=%0d error=%b ready=%b",
             rst_widths.size() - rw, bits.size() - b, bus.cfg_error, bus.clk_ready);

    // Reset during bit 4 of the M word
    lock_en = 1'b1;
    b = bits.size();
    issue(8'd30, 8'd31);
    n = 0;
    while ((bits.size() - b) != 15 && n < 200) begin
      step();
      n++;
    end
    check("midrst_reach_bit", bits.size() - b, 15);
    check("midrst_progen_before", bus.dcm_progen, 1);
    reset = 1'b1;
    step();
    check("midrst_progen", bus.dcm_progen, 0);
    check("midrst_dcm_reset", bus.dcm_reset, 1);
    check("midrst_busy", bus.cfg_busy, 0);
    $display("txn mid_reset: progen=%b dcm_reset=%b", bus.dcm_progen, bus.dcm_reset);
    step();
    b = bits.size();
    powerup_check("midrst_powerup");
    check("midrst_no_reprog", bits.size() - b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
